// File: rtl/bsg_counter_up_down_thermometer_pkg.sv
// Shared helpers for the thermometer up/down counter.
//   safe_clog2 : clog2 that never returns 0, so a 1-value range still gets a 1-bit port.
package bsg_counter_up_down_thermometer_pkg;

  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x < 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_thermometer_count.sv
// Decodes a thermometer code (ones packed from bit 0 upward) into a binary count.
//   therm_i : thermometer vector, width_p bits
//   count_o : number of ones, 0..width_p
// The decode takes the highest set bit, which equals the popcount only for a valid code.
module bsg_thermometer_count
  import bsg_counter_up_down_thermometer_pkg::*;
#(
  parameter int unsigned width_p = 16
) (
  input  logic [width_p-1:0]                    therm_i,
  output logic [safe_clog2(width_p+1)-1:0]      count_o
);

  localparam int unsigned CountW = safe_clog2(width_p + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(width_p); i++) begin
      if (therm_i[i]) count_o = CountW'(i + 1);
    end
  end

endmodule

// File: rtl/bsg_counter_up_down_thermometer.sv
// Up/down occupancy counter holding its state as a thermometer code.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, reloads init_val_p and clears err_o
//   up_i    : units added this cycle (0..max_step_p)
//   down_i  : units removed this cycle (0..max_step_p)
//   therm_o : registered state, therm_o[k] = 1 iff k < count
//   count_o : binary count decoded from therm_o
//   full_o  : count == width_p
//   empty_o : count == 0
//   err_o   : sticky overflow/underflow flag
module bsg_counter_up_down_thermometer
  import bsg_counter_up_down_thermometer_pkg::*;
#(
  parameter int unsigned width_p    = 16,
  parameter int unsigned max_step_p = 1,
  parameter int unsigned init_val_p = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [safe_clog2(max_step_p+1)-1:0]   up_i,
  input  logic [safe_clog2(max_step_p+1)-1:0]   down_i,
  output logic [width_p-1:0]                    therm_o,
  output logic [safe_clog2(width_p+1)-1:0]      count_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic                                  err_o
);

  localparam int unsigned StepW = safe_clog2(max_step_p + 1);
  // Shifting all-ones avoids overflowing a 32-bit (1<<n) when init_val_p reaches 32.
  localparam logic [width_p-1:0] InitTherm = ~({width_p{1'b1}} << init_val_p);

  logic [width_p-1:0]      therm_q, therm_d;
  logic                    err_q, err_d;
  logic signed [StepW:0]   net, neg_net;
  logic [StepW-1:0]        mag;
  int                      sum;

  // Up and down cancel before any boundary check.
  assign net     = $signed({1'b0, up_i}) - $signed({1'b0, down_i});
  assign neg_net = -net;
  assign sum     = int'(count_o) + int'(net);

  always_comb begin
    therm_d = therm_q;
    err_d   = err_q;
    mag     = '0;
    if (net > 0) begin
      mag = net[StepW-1:0];
      if (sum > int'(width_p)) begin
        therm_d = '1;
        err_d   = 1'b1;
      end else begin
        therm_d = (therm_q << mag) | ~({width_p{1'b1}} << mag);
      end
    end else if (net < 0) begin
      mag = neg_net[StepW-1:0];
      if (sum < 0) begin
        therm_d = '0;
        err_d   = 1'b1;
      end else begin
        therm_d = therm_q >> mag;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      therm_q <= InitTherm;
      err_q   <= 1'b0;
    end else begin
      therm_q <= therm_d;
      err_q   <= err_d;
    end
  end

  bsg_thermometer_count #(
    .width_p (width_p)
  ) u_count (
    .therm_i (therm_q),
    .count_o (count_o)
  );

  assign therm_o = therm_q;
  assign full_o  = therm_q[width_p-1];
  assign empty_o = ~therm_q[0];
  assign err_o   = err_q;

`ifndef SYNTHESIS
  step_legal_a : assert property (@(posedge clk_i) disable iff (reset_i)
    (32'(up_i) <= max_step_p) && (32'(down_i) <= max_step_p));
  therm_valid_a : assert property (@(posedge clk_i) disable iff (reset_i)
    ((therm_q & (therm_q + 1'b1)) == '0));
`endif

endmodule

// File: tb/tb_bsg_counter_up_down_thermometer.sv
module tb_bsg_counter_up_down_thermometer;

  localparam int W = 16;

  typedef struct packed {
    logic [15:0] therm;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  up_i, down_i;
  logic [15:0] therm_o;
  logic [4:0]  count_o;
  logic        full_o, empty_o, err_o;

  logic        reset_b;
  logic [1:0]  up_b, down_b;
  logic [15:0] therm_b;
  logic [4:0]  count_b;
  logic        full_b, empty_b, err_b;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   m_count;
  bit   m_err;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  bsg_counter_up_down_thermometer #(
    .width_p(16), .max_step_p(2), .init_val_p(0)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i),
    .therm_o(therm_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  bsg_counter_up_down_thermometer #(
    .width_p(16), .max_step_p(2), .init_val_p(16)
  ) dut_full (
    .clk_i(clk_i), .reset_i(reset_b), .up_i(up_b), .down_i(down_b),
    .therm_o(therm_b), .count_o(count_b), .full_o(full_b), .empty_o(empty_b), .err_o(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [31:0] t;
    t       = (32'd1 << m_count) - 32'd1;
    e.therm = t[15:0];
    e.count = 5'(m_count);
    e.full  = (m_count == W);
    e.empty = (m_count == 0);
    e.err   = m_err;
    return e;
  endfunction

  // Drive one cycle, advance the model, push its prediction, then pop and compare after the edge.
  task automatic step(input bit rst, input int up, input int dn);
    exp_t e;
    int c;
    reset_i = rst;
    up_i    = 2'(up);
    down_i  = 2'(dn);
    if (rst) begin
      m_count = 0;
      m_err   = 1'b0;
    end else begin
      c = m_count + up - dn;
      if (c > W) begin c = W; m_err = 1'b1; end
      if (c < 0) begin c = 0; m_err = 1'b1; end
      m_count = c;
    end
    sb_q.push_back(model_out());
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("therm", 32'(therm_o), 32'(e.therm));
      check("count", 32'(count_o), 32'(e.count));
      check("full",  32'(full_o),  32'(e.full));
      check("empty", 32'(empty_o), 32'(e.empty));
      check("err",   32'(err_o),   32'(e.err));
      check("therm_inv", 32'(therm_o & (therm_o + 16'd1)), 32'd0);
    end
  endtask

  initial begin
    m_count = 0;
    m_err   = 1'b0;
    reset_b = 1'b1;
    up_b    = '0;
    down_b  = '0;

    // Reset state, init 0
    step(1, 0, 0);
    step(1, 0, 0);
    check("reset_therm_const", 32'(therm_o), 32'h0000);

    // Increment, cancel, net -1
    repeat (3) step(0, 2, 0);
    check("up3_therm_const", 32'(therm_o), 32'h003F);
    step(0, 2, 2);
    step(0, 1, 2);
    check("net_neg_therm_const", 32'(therm_o), 32'h001F);

    // Overflow from 15 saturates and sets err; err remains sticky
    repeat (5) step(0, 2, 0);
    step(0, 2, 0);
    check("ovf_therm_const", 32'(therm_o), 32'hFFFF);
    step(0, 0, 2);
    check("sticky_err_const", 32'(err_o), 32'd1);

    // Underflow from 1
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 2);
    // Exact landing on 0 from 2 is legal
    step(1, 0, 0);
    step(0, 2, 0);
    step(0, 0, 2);
    // Exact landing on full is legal
    repeat (8) step(0, 2, 0);
    step(0, 0, 1);

    // Reset dominates in-flight update at count 9
    step(1, 0, 0);
    repeat (4) step(0, 2, 0);
    step(0, 1, 0);
    step(1, 2, 0);

    // init_val_p = 16 instance
    @(negedge clk_i);
    reset_b = 1'b0;
    @(posedge clk_i); #1;
    check("init16_therm", 32'(therm_b), 32'hFFFF);
    check("init16_full",  32'(full_b),  32'd1);
    check("init16_count", 32'(count_b), 32'd16);
    check("init16_err",   32'(err_b),   32'd0);

    // Random legal traffic against the model
    for (int i = 0; i < 10000; i++) begin
      step(0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hold the secondary instance in reset until its check point; its inputs stay idle.
  initial begin
    reset_b = 1'b1;
  end

endmodule
